// File: rtl/fanout_fork_ctrl.sv
// Eager fork: broadcasts one valid/ready token to up to NUM_OUT consumers, tracking
// which branches have already taken the current token so slow consumers do not stall the rest.
module fanout_fork_ctrl #(
  parameter int NUM_OUT    = 6,
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_OUT-1:0]              cfg_en,
  input  logic                            flush,
  input  logic                            in_valid,
  input  logic [DATA_WIDTH-1:0]           in_data,
  output logic                            in_ready,
  output logic [NUM_OUT-1:0]              out_valid,
  output logic [NUM_OUT*DATA_WIDTH-1:0]   out_data,
  input  logic [NUM_OUT-1:0]              out_ready,
  output logic                            idle,
  output logic [CNT_WIDTH-1:0]            tok_cnt,
  output logic [CNT_WIDTH-1:0]            stall_cnt
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  // Handshakes: a transfer happens on a branch (or upstream) in any cycle where valid
  // and ready are both high at the clock edge; valid must then hold with stable data until taken.
  logic [NUM_OUT-1:0] done;
  logic [NUM_OUT-1:0] acc;
  logic [NUM_OUT-1:0] branch_ok;
  logic               retire;
  logic               stall;

  always_comb begin
    out_valid = '0;
    branch_ok = '0;
    out_data  = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      out_valid[i]                           = ~rst & in_valid & cfg_en[i] & ~done[i];
      branch_ok[i]                           = ~cfg_en[i] | done[i] | out_ready[i];
      out_data[i*DATA_WIDTH +: DATA_WIDTH]   = in_data;
    end
    in_ready = ~rst & (&branch_ok);
    acc      = out_valid & out_ready;
    retire   = in_valid & in_ready;
    stall    = in_valid & ~in_ready;
  end

  // flush outranks retire/accumulate; reset clears done so a pending token is re-offered.
  always_ff @(posedge clk) begin
    if (rst) begin
      done      <= '0;
      tok_cnt   <= '0;
      stall_cnt <= '0;
    end else if (flush) begin
      done      <= '0;
      tok_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      if (retire) begin
        done <= '0;
        if (tok_cnt != CNT_MAX) tok_cnt <= tok_cnt + CNT_ONE;
      end else begin
        done <= done | acc;
      end
      if (stall && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

  assign idle = ~|done;

endmodule

// File: tb/tb_fanout_fork_ctrl.sv
// Bench for fanout_fork_ctrl: per-branch expected-token queues fed by the driver, drained
// by a negedge monitor that also predicts ready/valid/idle and the saturating counters.
module tb_fanout_fork_ctrl;

  localparam int NO   = 6;
  localparam int DW   = 16;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               flush = 1'b0;
  logic               in_valid = 1'b0;
  logic [DW-1:0]      in_data = '0;
  logic [NO-1:0]      cfg_en = '1;
  logic [NO-1:0]      out_ready = '0;
  logic               in_ready;
  logic [NO-1:0]      out_valid;
  logic [NO*DW-1:0]   out_data;
  logic               idle;
  logic [CW-1:0]      tok_cnt;
  logic [CW-1:0]      stall_cnt;

  always #5 clk = ~clk;

  fanout_fork_ctrl #(.NUM_OUT(NO), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .cfg_en(cfg_en), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .idle(idle), .tok_cnt(tok_cnt), .stall_cnt(stall_cnt)
  );

  // Upstream contract and configuration-change rule.
  assert property (@(posedge clk) disable iff (rst)
    (in_valid && !in_ready) |=> (in_valid && $stable(in_data)))
    else $error("in_valid dropped or in_data changed before retire");
  assert property (@(posedge clk) disable iff (rst || flush) $changed(cfg_en) |-> idle)
    else $error("cfg_en changed while a token was partially delivered");

  logic [DW-1:0] exp_q[NO][$];
  int            n_vec = 0;
  int            n_err = 0;
  int            m_tok = 0;
  int            m_stall = 0;
  logic [NO-1:0] rpat[64];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a branch owes the current token while its queue is non-empty; an empty
  // queue with in_valid high means that branch already took the token.
  always @(negedge clk) begin : monitor
    logic [NO-1:0] taken;
    logic [NO-1:0] exp_vld;
    logic          exp_rdy;
    logic [DW-1:0] front;
    for (int i = 0; i < NO; i++) begin
      taken[i]   = in_valid && (exp_q[i].size() == 0);
      exp_vld[i] = !rst && in_valid && cfg_en[i] && (exp_q[i].size() != 0);
    end
    exp_rdy = !rst && (&(~cfg_en | taken | out_ready));
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    check("out_valid", 32'(out_valid), 32'(exp_vld));
    check("idle", 32'(idle), 32'(~|(cfg_en & taken)));
    check("tok_cnt", 32'(tok_cnt), 32'(m_tok));
    check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
    for (int i = 0; i < NO; i++) begin
      if (exp_vld[i] && out_ready[i]) begin
        front = exp_q[i].pop_front();
        check($sformatf("out_data[%0d]", i), 32'(out_data[i*DW +: DW]), 32'(front));
      end
    end
    if (rst || flush) begin
      m_tok   = 0;
      m_stall = 0;
      for (int i = 0; i < NO; i++) begin
        exp_q[i].delete();
        if (in_valid && cfg_en[i]) exp_q[i].push_back(in_data);
      end
    end else if (in_valid && exp_rdy) begin
      m_tok = (m_tok == CMAX) ? CMAX : m_tok + 1;
    end else if (in_valid) begin
      m_stall = (m_stall == CMAX) ? CMAX : m_stall + 1;
    end
  end

  task automatic present(input logic [DW-1:0] d);
    in_data  = d;
    in_valid = 1'b1;
    for (int i = 0; i < NO; i++)
      if (cfg_en[i]) exp_q[i].push_back(d);
  endtask

  // rmode 0: all ready; 1: random ready; 2: scripted from rpat (all ready past the table).
  task automatic wait_retire(input int rmode);
    for (int c = 0; c < 200; c++) begin
      case (rmode)
        0:       out_ready = '1;
        1:       out_ready = NO'($urandom_range(0, (1 << NO) - 1));
        default: out_ready = (c < 64) ? rpat[c] : '1;
      endcase
      @(negedge clk);
      if (in_ready === 1'b1) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    n_vec++;
    n_err++;
    $display("FAIL retire_timeout: got no retire expected retire within 200 cycles at %0t", $time);
    in_valid = 1'b0;
    for (int i = 0; i < NO; i++) exp_q[i].delete();
  endtask

  task automatic flush_pulse();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  task automatic fill_rpat(input logic [NO-1:0] v);
    for (int i = 0; i < 64; i++) rpat[i] = v;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Back-to-back tokens with every branch ready.
    cfg_en = 6'h3F;
    for (int k = 0; k < 4; k++) begin
      present(16'hA000 + 16'(k));
      wait_retire(0);
    end
    check("t1_tok_cnt", 32'(tok_cnt), 32'd4);
    check("t1_stall_cnt", 32'(stall_cnt), 32'd0);

    // Staggered acceptance of one token.
    flush_pulse();
    fill_rpat(6'b000000);
    rpat[0] = 6'b000001;
    rpat[1] = 6'b011110;
    rpat[3] = 6'b100000;
    present(16'hBEEF);
    wait_retire(2);
    check("t2_stall_cnt", 32'(stall_cnt), 32'd3);
    check("t2_tok_cnt", 32'(tok_cnt), 32'd1);

    // Only branches 0 and 2 enabled; disabled branches never ready.
    flush_pulse();
    cfg_en = 6'b000101;
    fill_rpat(6'b000101);
    for (int k = 0; k < 5; k++) begin
      present(16'hC000 + 16'(k));
      wait_retire(2);
    end
    check("t3_tok_cnt", 32'(tok_cnt), 32'd5);
    check("t3_stall_cnt", 32'(stall_cnt), 32'd0);

    // No branch enabled: tokens drop but are counted.
    flush_pulse();
    cfg_en = '0;
    for (int k = 0; k < 5; k++) begin
      present(16'hD000 + 16'(k));
      wait_retire(1);
    end
    check("t4_tok_cnt", 32'(tok_cnt), 32'd5);

    // Partial delivery then flush, then partial delivery then reset.
    flush_pulse();
    cfg_en = 6'h3F;
    present(16'h5A5A);
    out_ready = 6'b000011;
    @(posedge clk);
    #1;
    out_ready = '0;
    check("t5_idle_partial", 32'(idle), 32'd0);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("t5_reoffer_flush", 32'(out_valid), 32'h3F);
    check("t5_tok_after_flush", 32'(tok_cnt), 32'd0);
    check("t5_stall_after_flush", 32'(stall_cnt), 32'd0);
    out_ready = 6'b000011;
    @(posedge clk);
    #1;
    out_ready = '0;
    rst = 1'b1;
    #1;
    check("t5_in_ready_rst", 32'(in_ready), 32'd0);
    check("t5_out_valid_rst", 32'(out_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("t5_reoffer_rst", 32'(out_valid), 32'h3F);
    wait_retire(0);
    check("t5_tok_after_rst", 32'(tok_cnt), 32'd1);

    // Stall counter saturation at 4 bits.
    flush_pulse();
    fill_rpat('1);
    for (int i = 0; i < 20; i++) rpat[i] = '0;
    present(16'hE0E0);
    wait_retire(2);
    check("t6_stall_sat", 32'(stall_cnt), 32'hF);

    // Randomized tokens, ready patterns, gaps and configurations.
    flush_pulse();
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 3) == 0) cfg_en = NO'($urandom_range(0, (1 << NO) - 1));
      if (n % 20 == 19) flush_pulse();
      present(DW'($urandom));
      wait_retire(1);
      begin
        int gap;
        gap = $urandom_range(0, 2);
        if (gap > 0) begin
          repeat (gap) @(posedge clk);
          #1;
        end
      end
    end

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
